// File: rtl/sad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sad_pkg
// Brief    : Shared types and helpers for the packed-SAD operand fetcher.
// Revision : 1.0
// ============================================================================
package sad_pkg;

    localparam int PIX_W = 8;
    localparam int LANES = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_PREW = 3'd2,
        ST_RD   = 3'd3,
        ST_CAP  = 3'd4,
        ST_OUT  = 3'd5,
        ST_DONE = 3'd6
    } sad_state_e;

    // Pixel offset of a byte address inside its 4-pixel word.
    function automatic logic [1:0] byte_off(input logic [31:0] byte_addr);
        return 2'(byte_addr % 32'(LANES));
    endfunction

endpackage
`default_nettype wire

// File: rtl/sad_byte_aligner.sv
`default_nettype none
// ============================================================================
// Module   : sad_byte_aligner
// Brief    : Funnel shift selecting four consecutive pixels from {hi, lo}.
// Revision : 1.0
// ============================================================================
module sad_byte_aligner
    import sad_pkg::*;
(
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    input  logic [1:0]  off,
    output logic [31:0] out
);

    // Offset 0 means the newly read word is already aligned, so it passes whole.
    always_comb begin
        out = hi;
        case (off)
            2'd1:    out = {hi[PIX_W-1:0],   lo[31:PIX_W]};
            2'd2:    out = {hi[2*PIX_W-1:0], lo[31:2*PIX_W]};
            2'd3:    out = {hi[3*PIX_W-1:0], lo[31:3*PIX_W]};
            default: out = hi;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/sad_operand_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : sad_operand_fetcher
// Brief    : Walks a candidate window and streams frame/window word pairs to
//            the 4x8-bit SAD unit. Optional SAD_FETCH_STALL_CNT_EN adds a
//            saturating backpressure counter on stall_cnt.
// Revision : 1.0
// ============================================================================
module sad_operand_fetcher
    import sad_pkg::*;
#(
    parameter int FRAME_W = 64,
    parameter int FRAME_H = 64,
    parameter int WIN_W   = 16,
    parameter int WIN_H   = 16,
    parameter int ADDR_W  = 16
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] frame_base,
    input  logic [ADDR_W-1:0] win_base,
    input  logic [15:0]       pos_x,
    input  logic [15:0]       pos_y,
    output logic              frm_rd,
    output logic [ADDR_W-1:0] frm_addr,
    input  logic [31:0]       frm_data,
    output logic              win_rd,
    output logic [ADDR_W-1:0] win_addr,
    input  logic [31:0]       win_data,
    output logic [31:0]       out_a,
    output logic [31:0]       out_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       stall_cnt
);

    localparam int          BYTE_W     = ADDR_W + 2;
    localparam logic [15:0] C_LAST_COL = 16'(WIN_W / LANES - 1);
    localparam logic [15:0] C_LAST_ROW = 16'(WIN_H - 1);

    sad_state_e        r_state;
    sad_state_e        w_next;
    logic [BYTE_W-1:0] r_row_byte;
    logic [BYTE_W-1:0] w_start_byte;
    logic [BYTE_W-1:0] w_next_row_byte;
    logic [ADDR_W-1:0] r_frm_ptr;
    logic [ADDR_W-1:0] r_win_ptr;
    logic [1:0]        r_off;
    logic [31:0]       r_hold;
    logic [31:0]       r_out_a;
    logic [31:0]       r_out_b;
    logic [31:0]       w_aligned;
    logic [15:0]       r_row;
    logic [15:0]       r_col;
    logic              r_valid;
    logic              r_last;
    logic              r_err;
    logic              w_range_err;
    logic              w_accept;
    logic              w_row_end;

    assign w_start_byte    = {frame_base, 2'b00}
                           + BYTE_W'(pos_y) * BYTE_W'(FRAME_W)
                           + BYTE_W'(pos_x);
    assign w_next_row_byte = r_row_byte + BYTE_W'(FRAME_W);
    assign w_range_err     = (pos_x > 16'(FRAME_W - WIN_W)) || (pos_y > 16'(FRAME_H - WIN_H));
    assign w_accept        = r_valid & out_ready;
    assign w_row_end       = (r_col == C_LAST_COL);

    assign frm_addr  = r_frm_ptr;
    assign win_addr  = r_win_ptr;
    assign out_a     = r_out_a;
    assign out_b     = r_out_b;
    assign out_valid = r_valid;
    assign out_last  = r_last;

    sad_byte_aligner u_aligner (
        .hi  (frm_data),
        .lo  (r_hold),
        .off (r_off),
        .out (w_aligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        frm_rd = 1'b0;
        win_rd = 1'b0;
        busy   = (r_state != ST_IDLE);
        done   = 1'b0;
        err    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (w_range_err)
                        w_next = ST_DONE;
                    else if (byte_off(32'(w_start_byte)) != 2'd0)
                        w_next = ST_PRE;
                    else
                        w_next = ST_RD;
                end
            end
            ST_PRE: begin
                frm_rd = 1'b1;
                w_next = ST_PREW;
            end
            ST_PREW: w_next = ST_RD;
            ST_RD: begin
                frm_rd = 1'b1;
                win_rd = 1'b1;
                w_next = ST_CAP;
            end
            ST_CAP: w_next = ST_OUT;
            ST_OUT: begin
                if (w_accept) begin
                    if (r_last)
                        w_next = ST_DONE;
                    else if (w_row_end && byte_off(32'(w_next_row_byte)) != 2'd0)
                        w_next = ST_PRE;
                    else
                        w_next = ST_RD;
                end
            end
            ST_DONE: begin
                done   = 1'b1;
                err    = r_err;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_byte <= '0;
            r_frm_ptr  <= '0;
            r_win_ptr  <= '0;
            r_off      <= 2'd0;
            r_hold     <= 32'd0;
            r_out_a    <= 32'd0;
            r_out_b    <= 32'd0;
            r_row      <= 16'd0;
            r_col      <= 16'd0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_err      <= w_range_err;
                        r_row_byte <= w_start_byte;
                        r_frm_ptr  <= w_start_byte[BYTE_W-1:2];
                        r_off      <= byte_off(32'(w_start_byte));
                        r_win_ptr  <= win_base;
                        r_row      <= 16'd0;
                        r_col      <= 16'd0;
                    end
                end
                ST_PREW: begin
                    r_hold    <= frm_data;
                    r_frm_ptr <= r_frm_ptr + ADDR_W'(1);
                end
                ST_CAP: begin
                    r_out_a <= w_aligned;
                    r_hold  <= frm_data;
                    r_out_b <= win_data;
                    r_valid <= 1'b1;
                    r_last  <= (r_row == C_LAST_ROW) && (r_col == C_LAST_COL);
                end
                ST_OUT: begin
                    if (w_accept) begin
                        r_valid   <= 1'b0;
                        r_last    <= 1'b0;
                        r_win_ptr <= r_win_ptr + ADDR_W'(1);
                        // Each row restarts from its own byte address so the offset can differ per row.
                        if (w_row_end) begin
                            r_row      <= r_row + 16'd1;
                            r_col      <= 16'd0;
                            r_row_byte <= w_next_row_byte;
                            r_frm_ptr  <= w_next_row_byte[BYTE_W-1:2];
                            r_off      <= byte_off(32'(w_next_row_byte));
                        end else begin
                            r_col     <= r_col + 16'd1;
                            r_frm_ptr <= r_frm_ptr + ADDR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SAD_FETCH_STALL_CNT_EN
    logic [15:0] r_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= 16'd0;
        end else if (r_state == ST_IDLE && start) begin
            r_stall <= 16'd0;
        end else if (r_valid && !out_ready && r_stall != 16'hFFFF) begin
            r_stall <= r_stall + 16'd1;
        end
    end

    assign stall_cnt = r_stall;
`else
    assign stall_cnt = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sad_operand_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_sad_operand_fetcher
// Brief    : Self-checking bench: RAM models, randomized fetches, reference model.
// Revision : 1.0
// ============================================================================
module tb_sad_operand_fetcher;

    localparam int FRAME_W = 64;
    localparam int FRAME_H = 64;
    localparam int WIN_W   = 16;
    localparam int WIN_H   = 16;
    localparam int ADDR_W  = 16;
    localparam int COLS    = WIN_W / 4;
    localparam int NPAIR   = WIN_H * COLS;
`ifdef SAD_FETCH_STALL_CNT_EN
    localparam int EXP_STALL = 5;
`else
    localparam int EXP_STALL = 0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] frame_base = '0;
    logic [ADDR_W-1:0] win_base = '0;
    logic [15:0]       pos_x = '0;
    logic [15:0]       pos_y = '0;
    logic              frm_rd;
    logic [ADDR_W-1:0] frm_addr;
    logic [31:0]       frm_data = '0;
    logic              win_rd;
    logic [ADDR_W-1:0] win_addr;
    logic [31:0]       win_data = '0;
    logic [31:0]       out_a;
    logic [31:0]       out_b;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              out_last;
    logic              busy;
    logic              done;
    logic              err;
    logic [15:0]       stall_cnt;

    int          n_vec = 0;
    int          n_err = 0;
    int unsigned win_seed = 32'h1234_5678;

    logic [31:0] obs_a[$];
    logic [31:0] obs_b[$];
    bit          obs_last[$];
    int          first_valid_cyc, done_cyc, done_cnt, last_acc_cyc, first_frm_addr, stall_at_accept;
    bit          err_at_done, any_rd, timed_out, unstable, aborted;

    always #5 clk = ~clk;

    sad_operand_fetcher #(
        .FRAME_W (FRAME_W), .FRAME_H (FRAME_H), .WIN_W (WIN_W), .WIN_H (WIN_H), .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .frame_base (frame_base),
        .win_base   (win_base),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .frm_rd     (frm_rd),
        .frm_addr   (frm_addr),
        .frm_data   (frm_data),
        .win_rd     (win_rd),
        .win_addr   (win_addr),
        .win_data   (win_data),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .stall_cnt  (stall_cnt)
    );

    // Frame RAM holds byte k = k[7:0]; window RAM holds a seeded hash of the address.
    function automatic logic [31:0] frame_word(input logic [ADDR_W-1:0] a);
        logic [ADDR_W+1:0] b;
        b = {a, 2'b00};
        return {8'(b + 3), 8'(b + 2), 8'(b + 1), 8'(b)};
    endfunction

    function automatic logic [31:0] win_word(input logic [ADDR_W-1:0] a);
        return (32'(a) * 32'h9E37_79B1) ^ win_seed;
    endfunction

    always @(posedge clk) begin
        if (frm_rd) frm_data <= frame_word(frm_addr);
        if (win_rd) win_data <= win_word(win_addr);
    end

    // Reference model: pixels by coordinates, cycle budget by row alignment.
    function automatic logic [31:0] exp_a(input int fb, input int px, input int py, input int p);
        logic [31:0] res;
        int b;
        res = '0;
        for (int i = 0; i < 4; i++) begin
            b = fb * 4 + (py + p / COLS) * FRAME_W + px + 4 * (p % COLS) + i;
            res[8*i +: 8] = 8'(b);
        end
        return res;
    endfunction

    function automatic logic [31:0] exp_b(input int wb, input int p);
        return win_word(ADDR_W'(wb + p));
    endfunction

    function automatic int exp_done_cyc(input int fb, input int px, input int py);
        int cyc;
        cyc = 1;
        for (int r = 0; r < WIN_H; r++)
            cyc += 3 * COLS + ((((fb * 4 + (py + r) * FRAME_W + px) % 4) != 0) ? 2 : 0);
        return cyc;
    endfunction

    // Drives one fetch and records what the DUT emits; comparisons live in the test tasks.
    task automatic run_window(input logic [15:0] fb, input logic [15:0] wb, input logic [15:0] px,
                              input logic [15:0] py, input int ready_pct, input int stall_n,
                              input int abort_after, input bit poke_start);
        int cyc, stall_left, post;
        bit seen_valid;
        logic [31:0] hold_a, hold_b;
        obs_a.delete(); obs_b.delete(); obs_last.delete();
        first_valid_cyc = -1; done_cyc = -1; done_cnt = 0; last_acc_cyc = -2;
        first_frm_addr = -1; stall_at_accept = -1;
        err_at_done = 0; any_rd = 0; timed_out = 0; unstable = 0; aborted = 0;
        seen_valid = 0; stall_left = 0; post = -1; hold_a = '0; hold_b = '0;
        @(posedge clk); #1;
        frame_base = fb; win_base = wb; pos_x = px; pos_y = py; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (cyc < 3000) begin
            if (frm_rd || win_rd) any_rd = 1;
            if (frm_rd && first_frm_addr < 0) first_frm_addr = int'(frm_addr);
            if (poke_start && done_cyc < 0) begin
                start = ((cyc % 23) == 7);
                pos_x = 16'($urandom);
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc; err_at_done = err; start = 1'b0; post = 3;
                end
            end
            if (out_valid) begin
                if (!seen_valid) begin
                    seen_valid = 1; first_valid_cyc = cyc; stall_left = stall_n;
                    hold_a = out_a; hold_b = out_b;
                end
                if (abort_after >= 0 && obs_a.size() == abort_after) begin
                    aborted = 1; out_ready = 1'b0;
                    return;
                end
                if (stall_left > 0) begin
                    if (out_a !== hold_a || out_b !== hold_b) unstable = 1;
                    out_ready = 1'b0;
                    stall_left--;
                end else begin
                    if (stall_n > 0 && stall_at_accept < 0) begin
                        stall_at_accept = int'(stall_cnt);
                        if (out_a !== hold_a || out_b !== hold_b) unstable = 1;
                    end
                    out_ready = ($urandom_range(99) < ready_pct);
                    if (out_ready) begin
                        obs_a.push_back(out_a); obs_b.push_back(out_b); obs_last.push_back(out_last);
                        if (out_last) last_acc_cyc = cyc + 1;
                    end
                end
            end else begin
                out_ready = ($urandom_range(99) < ready_pct);
            end
            if (post == 0) break;
            if (post > 0) post--;
            @(posedge clk); #1;
            cyc++;
        end
        timed_out = (done_cyc < 0);
        start = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({frm_rd, frm_addr, win_rd, win_addr, out_a, out_b, out_valid, out_last,
             busy, done, err, stall_cnt} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got a=%h b=%h valid=%b busy=%b done=%b faddr=%h, want all zero",
                     out_a, out_b, out_valid, busy, done, frm_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_aligned();
        int wb;
        wb = int'($urandom_range(65535));
        run_window(16'd0, 16'(wb), 16'd0, 16'd0, 100, 0, -1, 0);
        n_vec++;
        if (timed_out) begin n_err++; $display("FAIL aligned_timeout: got no done, want done"); end
        n_vec++;
        if (first_valid_cyc != 3) begin n_err++; $display("FAIL aligned_latency: got %0d want 3", first_valid_cyc); end
        n_vec++;
        if (obs_a.size() != NPAIR) begin n_err++; $display("FAIL aligned_pairs: got %0d want %0d", obs_a.size(), NPAIR); end
        n_vec++;
        if (obs_a.size() == 0 || obs_a[0] !== 32'h0302_0100) begin
            n_err++; $display("FAIL aligned_first_a: got %h want 03020100", (obs_a.size() > 0) ? obs_a[0] : 32'hx);
        end
        for (int p = 0; p < obs_a.size() && p < NPAIR; p++) begin
            n_vec++;
            if (obs_a[p] !== exp_a(0, 0, 0, p) || obs_b[p] !== exp_b(wb, p) || obs_last[p] !== (p == NPAIR - 1)) begin
                n_err++;
                $display("FAIL aligned_pair%0d: got a=%h b=%h last=%b want a=%h b=%h last=%b", p,
                         obs_a[p], obs_b[p], obs_last[p], exp_a(0, 0, 0, p), exp_b(wb, p), p == NPAIR - 1);
            end
        end
        n_vec++;
        if (done_cnt != 1 || err_at_done !== 1'b0) begin
            n_err++; $display("FAIL aligned_done: got done_cnt=%0d err=%b want 1 and 0", done_cnt, err_at_done);
        end
        n_vec++;
        if (done_cyc != exp_done_cyc(0, 0, 0) || done_cyc != last_acc_cyc) begin
            n_err++; $display("FAIL aligned_done_cycle: got %0d (last accept %0d) want %0d",
                              done_cyc, last_acc_cyc, exp_done_cyc(0, 0, 0));
        end
    endtask

    task automatic test_unaligned();
        run_window(16'd0, 16'd100, 16'd1, 16'd0, 100, 0, -1, 0);
        n_vec++;
        if (first_valid_cyc != 5) begin n_err++; $display("FAIL unaligned_latency: got %0d want 5", first_valid_cyc); end
        n_vec++;
        if (obs_a.size() < 2 || obs_a[0] !== 32'h0403_0201 || obs_a[1] !== 32'h0807_0605) begin
            n_err++; $display("FAIL unaligned_first_words: got %h %h want 04030201 08070605",
                              (obs_a.size() > 0) ? obs_a[0] : 32'hx, (obs_a.size() > 1) ? obs_a[1] : 32'hx);
        end
        n_vec++;
        if (done_cyc != exp_done_cyc(0, 1, 0)) begin
            n_err++; $display("FAIL unaligned_done_cycle: got %0d want %0d", done_cyc, exp_done_cyc(0, 1, 0));
        end
    endtask

    task automatic test_row_offset();
        run_window(16'd0, 16'd0, 16'd4, 16'd1, 100, 0, -1, 0);
        n_vec++;
        if (first_frm_addr != 17) begin n_err++; $display("FAIL row1_first_addr: got %0d want 17", first_frm_addr); end
        n_vec++;
        if (obs_a.size() == 0 || obs_a[0] !== 32'h4746_4544) begin
            n_err++; $display("FAIL row1_first_a: got %h want 47464544", (obs_a.size() > 0) ? obs_a[0] : 32'hx);
        end
    endtask

    task automatic test_stall();
        run_window(16'd0, 16'd7, 16'd0, 16'd0, 100, 5, -1, 0);
        n_vec++;
        if (unstable) begin n_err++; $display("FAIL stall_hold: got outputs changing while stalled, want stable"); end
        n_vec++;
        if (stall_at_accept != EXP_STALL) begin
            n_err++; $display("FAIL stall_count: got %0d want %0d", stall_at_accept, EXP_STALL);
        end
        n_vec++;
        if (obs_a.size() != NPAIR || obs_b[0] !== exp_b(7, 0)) begin
            n_err++; $display("FAIL stall_pairs: got %0d pairs want %0d", obs_a.size(), NPAIR);
        end
    endtask

    task automatic test_out_of_range();
        run_window(16'd0, 16'd0, 16'd49, 16'd0, 100, 0, -1, 0);
        n_vec++;
        if (done_cyc != 1 || err_at_done !== 1'b1 || done_cnt != 1) begin
            n_err++; $display("FAIL oor_x_done: got cyc=%0d err=%b cnt=%0d want 1 1 1", done_cyc, err_at_done, done_cnt);
        end
        n_vec++;
        if (any_rd || obs_a.size() != 0) begin
            n_err++; $display("FAIL oor_x_reads: got rd=%b pairs=%0d want 0 0", any_rd, obs_a.size());
        end
        run_window(16'd0, 16'd0, 16'd3, 16'd49, 100, 0, -1, 0);
        n_vec++;
        if (done_cyc != 1 || err_at_done !== 1'b1 || any_rd) begin
            n_err++; $display("FAIL oor_y: got cyc=%0d err=%b rd=%b want 1 1 0", done_cyc, err_at_done, any_rd);
        end
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        run_window(16'd0, 16'd0, 16'd0, 16'd0, 100, 0, 10, 0);
        n_vec++;
        if (!aborted) begin n_err++; $display("FAIL midreset_reach: got no OUT at pair 10, want it reached"); end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({frm_rd, frm_addr, win_rd, win_addr, out_a, out_b, out_valid, out_last,
             busy, done, err, stall_cnt} !== '0) begin
            n_err++; $display("FAIL midreset_outputs: got a=%h valid=%b busy=%b, want all zero", out_a, out_valid, busy);
        end
        saw_done = 0;
        repeat (2) begin @(posedge clk); #1; if (done) saw_done = 1; end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; if (done || busy) saw_done = 1; end
        n_vec++;
        if (saw_done) begin n_err++; $display("FAIL midreset_no_done: got done/busy after abort, want 0"); end
        win_seed = 32'h1234_5678;
        run_window(16'd0, 16'd0, 16'd0, 16'd0, 100, 0, -1, 0);
        n_vec++;
        if (first_valid_cyc != 3 || done_cnt != 1 || done_cyc != exp_done_cyc(0, 0, 0) || obs_a.size() != NPAIR) begin
            n_err++; $display("FAIL midreset_rerun: got lat=%0d done=%0d cyc=%0d pairs=%0d want 3 1 %0d %0d",
                              first_valid_cyc, done_cnt, done_cyc, obs_a.size(), exp_done_cyc(0, 0, 0), NPAIR);
        end
        for (int p = 0; p < obs_a.size() && p < NPAIR; p++) begin
            n_vec++;
            if (obs_a[p] !== exp_a(0, 0, 0, p) || obs_b[p] !== exp_b(0, p)) begin
                n_err++; $display("FAIL midreset_pair%0d: got a=%h b=%h want a=%h b=%h", p,
                                  obs_a[p], obs_b[p], exp_a(0, 0, 0, p), exp_b(0, p));
            end
        end
    endtask

    task automatic test_random();
        int fb, wb, px, py, pct, bad;
        for (int it = 0; it < 6; it++) begin
            win_seed = $urandom;
            fb  = int'($urandom_range(65535));
            wb  = int'($urandom_range(65535));
            px  = (it == 0) ? FRAME_W - WIN_W : int'($urandom_range(FRAME_W - WIN_W));
            py  = (it == 0) ? FRAME_H - WIN_H : int'($urandom_range(FRAME_H - WIN_H));
            pct = int'($urandom_range(100, 30));
            run_window(16'(fb), 16'(wb), 16'(px), 16'(py), pct, 0, -1, it[0]);
            n_vec++;
            if (timed_out || done_cnt != 1 || err_at_done !== 1'b0 || obs_a.size() != NPAIR || done_cyc != last_acc_cyc) begin
                n_err++; $display("FAIL random%0d_done: got to=%b done=%0d err=%b pairs=%0d cyc=%0d/%0d want 0 1 0 %0d equal",
                                  it, timed_out, done_cnt, err_at_done, obs_a.size(), done_cyc, last_acc_cyc, NPAIR);
            end
            bad = 0;
            for (int p = 0; p < obs_a.size() && p < NPAIR; p++) begin
                if (obs_a[p] !== exp_a(fb, px, py, p) || obs_b[p] !== exp_b(wb, p) || obs_last[p] !== (p == NPAIR - 1)) begin
                    if (bad == 0)
                        $display("FAIL random%0d_pair%0d: got a=%h b=%h want a=%h b=%h (fb=%0d px=%0d py=%0d)", it, p,
                                 obs_a[p], obs_b[p], exp_a(fb, px, py, p), exp_b(wb, p), fb, px, py);
                    bad++;
                end
            end
            n_vec++;
            if (bad != 0) begin n_err++; $display("FAIL random%0d_pairs: got %0d bad pairs want 0", it, bad); end
        end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_unaligned();
        test_row_offset();
        test_stall();
        test_out_of_range();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
